// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator: scans operands MSB-first, D bits per cycle, and stops on
// the first differing digit. Reports lt/eq/gt plus the number of digits scanned.
module serial_magnitude_comparator #(
    parameter int unsigned N      = 8,
    parameter int unsigned D      = 1,
    parameter int unsigned SIGNED = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [N-1:0]                    a_i,
    input  logic [N-1:0]                    b_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic                            lt_o,
    output logic                            eq_o,
    output logic                            gt_o,
    output logic [$clog2(N/D+1)-1:0]        digits_o
);

    localparam int unsigned NumDigits = N / D;
    localparam int unsigned CntW      = $clog2(NumDigits + 1);
    // Flipping the sign bit maps two's complement onto offset binary, so the scan stays unsigned.
    localparam logic [N-1:0] SignMask = (SIGNED != 0) ? (N'(1) << (N - 1)) : '0;

    if ((N == 0) || (D == 0) || ((N % D) != 0)) begin : g_bad_digit
        $error("serial_magnitude_comparator: N must be a non-zero multiple of D");
    end

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    sa_q, sa_d;
    logic [N-1:0]    sb_q, sb_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] digits_q, digits_d;
    logic            lt_q, lt_d;
    logic            eq_q, eq_d;
    logic            gt_q, gt_d;

    logic [D-1:0] da, db;
    assign da = sa_q[N-1 -: D];
    assign db = sb_q[N-1 -: D];

    always_comb begin
        state_d     = state_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        cnt_d       = cnt_q;
        digits_d    = digits_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    sa_d    = a_i ^ SignMask;
                    sb_d    = b_i ^ SignMask;
                    cnt_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (da != db) begin
                    lt_d     = (da < db);
                    gt_d     = (da > db);
                    eq_d     = 1'b0;
                    digits_d = cnt_q + CntW'(1);
                    state_d  = StDone;
                end else if (cnt_q == CntW'(NumDigits - 1)) begin
                    lt_d     = 1'b0;
                    gt_d     = 1'b0;
                    eq_d     = 1'b1;
                    digits_d = CntW'(NumDigits);
                    state_d  = StDone;
                end else begin
                    sa_d  = sa_q << D;
                    sb_d  = sb_q << D;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
        end
    end

    assign lt_o     = lt_q;
    assign eq_o     = eq_q;
    assign gt_o     = gt_q;
    assign digits_o = digits_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator: three instances (unsigned D=1, signed D=1,
// unsigned D=4) driven with directed and random operand pairs against a behavioural model.
module tb_serial_magnitude_comparator;

    typedef struct packed {
        logic        lt;
        logic        eq;
        logic        gt;
        logic [3:0]  dig;
        logic [31:0] e0;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       iv   [3];
    logic       ir   [3];
    logic [7:0] a_r  [3];
    logic [7:0] b_r  [3];
    logic       ov   [3];
    logic       ordy [3];
    logic       lt   [3];
    logic       eq   [3];
    logic       gt   [3];
    logic [3:0] dig  [3];
    logic [3:0] dig0, dig1;
    logic [1:0] dig2;
    bit         hold_bp [3];

    int unsigned cyc;
    int          checks;
    int          failures;
    exp_t        exp_q [3][$];

    assign dig[0] = dig0;
    assign dig[1] = dig1;
    assign dig[2] = {2'b00, dig2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_magnitude_comparator #(.N(8), .D(1), .SIGNED(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
        .a_i(a_r[0]), .b_i(b_r[0]), .out_valid_o(ov[0]), .out_ready_i(ordy[0]),
        .lt_o(lt[0]), .eq_o(eq[0]), .gt_o(gt[0]), .digits_o(dig0)
    );

    serial_magnitude_comparator #(.N(8), .D(1), .SIGNED(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
        .a_i(a_r[1]), .b_i(b_r[1]), .out_valid_o(ov[1]), .out_ready_i(ordy[1]),
        .lt_o(lt[1]), .eq_o(eq[1]), .gt_o(gt[1]), .digits_o(dig1)
    );

    serial_magnitude_comparator #(.N(8), .D(4), .SIGNED(0)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
        .a_i(a_r[2]), .b_i(b_r[2]), .out_valid_o(ov[2]), .out_ready_i(ordy[2]),
        .lt_o(lt[2]), .eq_o(eq[2]), .gt_o(gt[2]), .digits_o(dig2)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: ordering from plain integer comparison; digits from the first non-zero digit
    // of a^b (the sign-bit flip cancels in the xor).
    function automatic exp_t model(input int u, input logic [7:0] a, input logic [7:0] b);
        exp_t        m;
        int          dw;
        int          nd;
        int          k;
        bit          found;
        logic [7:0]  x;
        int unsigned digit;
        dw    = (u == 2) ? 4 : 1;
        nd    = 8 / dw;
        x     = a ^ b;
        k     = nd;
        found = 1'b0;
        for (int i = 0; i < nd; i++) begin
            digit = (int'(x) >> (8 - (i + 1) * dw)) & ((1 << dw) - 1);
            if (!found && digit != 0) begin
                k     = i + 1;
                found = 1'b1;
            end
        end
        if (u == 1) begin
            m.lt = ($signed(a) < $signed(b));
            m.gt = ($signed(a) > $signed(b));
        end else begin
            m.lt = (a < b);
            m.gt = (a > b);
        end
        m.eq  = (a == b);
        m.dig = 4'(k);
        m.e0  = '0;
        return m;
    endfunction

    task automatic issue(input int u, input logic [7:0] a, input logic [7:0] b);
        exp_t m;
        int   n;
        n = 0;
        @(negedge clk);
        while (!ir[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir[u]) begin
            chk("in_ready_timeout", 0, 1);
        end else begin
            iv[u]  = 1'b1;
            a_r[u] = a;
            b_r[u] = b;
            m      = model(u, a, b);
            @(posedge clk);
            #1;
            m.e0 = cyc;
            exp_q[u].push_back(m);
            iv[u]  = 1'b0;
            a_r[u] = 8'($urandom);
            b_r[u] = 8'($urandom);
        end
    endtask

    task automatic drain(input int u);
        int n;
        n = 0;
        while ((exp_q[u].size() != 0 || ov[u]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q[u].size(), 0);
    endtask

    task automatic check_reset_state(input int u);
        chk("rst_out_valid", ov[u], 0);
        chk("rst_in_ready", ir[u], 1);
        chk("rst_lt", lt[u], 0);
        chk("rst_eq", eq[u], 0);
        chk("rst_gt", gt[u], 0);
        chk("rst_digits", dig[u], 0);
    endtask

    // Random out_ready, changed just after each rising edge so it is stable for the monitors.
    initial begin
        for (int u = 0; u < 3; u++) ordy[u] = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            for (int u = 0; u < 3; u++) begin
                ordy[u] = hold_bp[u] ? 1'b0 : ($urandom_range(0, 3) != 0);
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_mon
        initial begin
            exp_t cur;
            bit   prev;
            bit   hs;
            prev = 1'b0;
            hs   = 1'b0;
            cur  = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev = 1'b0;
                    hs   = 1'b0;
                end else begin
                    if (hs) begin
                        chk("idle_after_hs_valid", ov[g], 0);
                        chk("idle_after_hs_ready", ir[g], 1);
                    end
                    if (ov[g]) begin
                        if (!prev) begin
                            if (exp_q[g].size() == 0) begin
                                chk("unexpected_result", exp_q[g].size(), 1);
                            end else begin
                                cur = exp_q[g].pop_front();
                                chk("latency", cyc - cur.e0, cur.dig);
                            end
                        end
                        chk("lt", lt[g], cur.lt);
                        chk("eq", eq[g], cur.eq);
                        chk("gt", gt[g], cur.gt);
                        chk("digits", dig[g], cur.dig);
                        chk("onehot", $countones({lt[g], eq[g], gt[g]}), 1);
                        chk("busy_in_ready", ir[g], 0);
                    end
                    hs   = ov[g] && ordy[g];
                    prev = ov[g];
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        for (int u = 0; u < 3; u++) begin
            iv[u]      = 1'b0;
            a_r[u]     = '0;
            b_r[u]     = '0;
            hold_bp[u] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) check_reset_state(u);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        issue(0, 8'h10, 8'h20);
        issue(0, 8'hA5, 8'hA5);
        issue(0, 8'h80, 8'h7F);
        drain(0);
        issue(1, 8'h80, 8'h7F);
        issue(1, 8'hFF, 8'hFE);
        issue(1, 8'h7F, 8'h7F);
        drain(1);
        issue(2, 8'h12, 8'h13);
        issue(2, 8'h40, 8'h30);
        issue(2, 8'h3C, 8'h3C);
        drain(2);

        // Backpressure: result held for 5 cycles while in_valid pulses are ignored
        hold_bp[0] = 1'b1;
        issue(0, 8'h10, 8'h20);
        for (int n = 0; n < 50 && !ov[0]; n++) @(negedge clk);
        chk("bp_valid_seen", ov[0], 1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            iv[0]  = n[0];
            a_r[0] = 8'($urandom);
            b_r[0] = 8'($urandom);
        end
        @(negedge clk);
        iv[0]      = 1'b0;
        hold_bp[0] = 1'b0;
        drain(0);

        // Reset mid-scan discards the in-flight compare
        issue(0, 8'hA5, 8'hA5);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state(0);
        exp_q[0].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 8'h33, 8'h31);
        drain(0);

        // Random traffic, biased towards long common prefixes
        for (int t = 0; t < 120; t++) begin
            int         u;
            logic [7:0] a;
            logic [7:0] b;
            u = t % 3;
            a = 8'($urandom);
            b = ($urandom_range(0, 2) == 0) ? a : (a ^ 8'(1 << $urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            issue(u, a, b);
        end
        for (int u = 0; u < 3; u++) drain(u);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
